// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register (F1), memory-response tag (F2) and IF/ID register.
// Next PC is chosen from an ID redirect, a stall hold, the branch prediction or pc+4.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_fetch,
  input  logic        bp_prediction_taken,
  input  logic [31:0] bp_predicted_target,
  input  logic [1:0]  bp_state,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_pred_taken,
  output logic [31:0] ifid_pred_target,
  output logic [1:0]  ifid_bp_state
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_pc_aligned;
  logic [31:0] pred_target_aligned;

  // F2 tag: describes the request whose data is currently on imem_rdata
  logic        f2_valid_q;
  logic [31:0] f2_pc_q;
  logic        f2_pred_taken_q;
  logic [31:0] f2_pred_target_q;
  logic [1:0]  f2_state_q;

  logic        ifid_valid_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_instr_q;
  logic        ifid_pred_taken_q;
  logic [31:0] ifid_pred_target_q;
  logic [1:0]  ifid_bp_state_q;

  // Low address bits are dropped on both redirect and predicted targets
  logic unused_low_bits;
  assign unused_low_bits = ^{redirect_pc[1:0], bp_predicted_target[1:0]};

  assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};
  assign pred_target_aligned = {bp_predicted_target[31:2], 2'b00};

  assign pc_fetch  = pc_q;
  assign imem_addr = pc_q;
  assign imem_en   = ~rst & (~stall | redirect_en);

  assign ifid_valid       = ifid_valid_q;
  assign ifid_pc          = ifid_pc_q;
  assign ifid_instr       = ifid_instr_q;
  assign ifid_pred_taken  = ifid_pred_taken_q;
  assign ifid_pred_target = ifid_pred_target_q;
  assign ifid_bp_state    = ifid_bp_state_q;

  // Next-PC select: redirect > stall > predicted taken > sequential
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (redirect_en) begin
      pc_d = redirect_pc_aligned;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (bp_prediction_taken) begin
      pc_d = pred_target_aligned;
    end
  end

  // F1: PC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // F2: tag the issued request with its PC and the prediction that steered next-PC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f2_valid_q       <= 1'b0;
      f2_pc_q          <= '0;
      f2_pred_taken_q  <= 1'b0;
      f2_pred_target_q <= '0;
      f2_state_q       <= '0;
    end else if (redirect_en) begin
      f2_valid_q <= 1'b0;
    end else if (!stall) begin
      f2_valid_q       <= 1'b1;
      f2_pc_q          <= pc_q;
      f2_pred_taken_q  <= bp_prediction_taken;
      f2_pred_target_q <= pred_target_aligned;
      f2_state_q       <= bp_state;
    end
  end

  // IF/ID: join the F2 tag with the returned instruction word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_valid_q       <= 1'b0;
      ifid_pc_q          <= '0;
      ifid_instr_q       <= NOP_INSTR;
      ifid_pred_taken_q  <= 1'b0;
      ifid_pred_target_q <= '0;
      ifid_bp_state_q    <= '0;
    end else if (redirect_en) begin
      ifid_valid_q       <= 1'b0;
      ifid_pc_q          <= '0;
      ifid_instr_q       <= NOP_INSTR;
      ifid_pred_taken_q  <= 1'b0;
      ifid_pred_target_q <= '0;
      ifid_bp_state_q    <= '0;
    end else if (!stall) begin
      ifid_valid_q       <= f2_valid_q;
      ifid_pc_q          <= f2_pc_q;
      ifid_instr_q       <= f2_valid_q ? imem_rdata : NOP_INSTR;
      ifid_pred_taken_q  <= f2_pred_taken_q;
      ifid_pred_target_q <= f2_pred_target_q;
      ifid_bp_state_q    <= f2_state_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a program-order fetch model pushes the expected IF/ID
// view for every clock edge; a separate monitor pops and compares after each edge.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] pc_fetch;
  logic        bp_prediction_taken;
  logic [31:0] bp_predicted_target;
  logic [1:0]  bp_state;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_pred_taken;
  logic [31:0] ifid_pred_target;
  logic [1:0]  ifid_bp_state;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .redirect_en        (redirect_en),
    .redirect_pc        (redirect_pc),
    .pc_fetch           (pc_fetch),
    .bp_prediction_taken(bp_prediction_taken),
    .bp_predicted_target(bp_predicted_target),
    .bp_state           (bp_state),
    .imem_en            (imem_en),
    .imem_addr          (imem_addr),
    .imem_rdata         (imem_rdata),
    .ifid_valid         (ifid_valid),
    .ifid_pc            (ifid_pc),
    .ifid_instr         (ifid_instr),
    .ifid_pred_taken    (ifid_pred_taken),
    .ifid_pred_target   (ifid_pred_target),
    .ifid_bp_state      (ifid_bp_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Predictor environment: one directed entry plus optional pseudo-random branches
  logic        d_en;
  logic [31:0] d_pc, d_tgt;
  logic [1:0]  d_st;
  logic        rnd_pred;

  typedef struct packed {
    logic        taken;
    logic [31:0] tgt;
    logic [1:0]  st;
  } pred_t;

  function automatic logic [31:0] hash(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h045D_9F3B;
    h = h ^ (h >> 16);
    return h;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic pred_t pred(input logic [31:0] pc);
    pred_t p;
    logic [31:0] h;
    h = hash(pc);
    p.taken = rnd_pred && (h[2:0] == 3'd0);
    p.tgt   = hash(pc ^ 32'h5555_AAAA);
    p.st    = h[4:3];
    if (d_en && pc == d_pc) begin
      p.taken = 1'b1;
      p.tgt   = d_tgt;
      p.st    = d_st;
    end
    return p;
  endfunction

  // Predictor responds combinationally to the current fetch PC
  always_comb begin
    pred_t p;
    p = pred(pc_fetch);
    bp_prediction_taken = p.taken;
    bp_predicted_target = p.tgt;
    bp_state            = p.st;
  end

  // Synchronous instruction memory, 1-cycle latency, holds data when not enabled
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [31:0] tgt;
    logic [1:0]  st;
    logic        known;  // tag fields checkable (not a stale bubble)
    logic [31:0] pcf;
  } exp_t;

  exp_t exp_q[$];
  exp_t inflight[$];  // fetched but not yet delivered to ID, in program order
  exp_t cur;          // what ID should see now
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t zero_bubble();
    exp_t e;
    e.valid = 1'b0; e.pc = '0; e.instr = NOP; e.taken = 1'b0;
    e.tgt = '0; e.st = '0; e.known = 1'b1; e.pcf = '0;
    return e;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC;
    inflight.delete();
    cur = zero_bubble();
  endtask

  task automatic check_reset();
    chk("rst_pc_fetch", pc_fetch, RST_PC);
    chk("rst_imem_en", imem_en, 0);
    chk("rst_ifid_valid", ifid_valid, 0);
    chk("rst_ifid_instr", ifid_instr, NOP);
    chk("rst_ifid_pc", ifid_pc, 0);
    chk("rst_ifid_taken", ifid_pred_taken, 0);
    chk("rst_ifid_target", ifid_pred_target, 0);
    chk("rst_ifid_state", ifid_bp_state, 0);
  endtask

  // Apply inputs for the coming edge and push the expected post-edge view
  task automatic drive(input logic s, input logic r, input logic [31:0] rpc);
    pred_t p;
    exp_t  f;
    stall = s; redirect_en = r; redirect_pc = rpc;
    #1;
    chk("imem_en", imem_en, (!s || r) ? 1 : 0);
    if (r) begin
      inflight.delete();
      cur  = zero_bubble();
      m_pc = {rpc[31:2], 2'b00};
    end else if (!s) begin
      if (inflight.size() > 0) begin
        cur = inflight.pop_front();
      end else begin
        cur.valid = 1'b0; cur.instr = NOP; cur.known = 1'b0;
      end
      p = pred(m_pc);
      f.valid = 1'b1; f.pc = m_pc; f.instr = mem_word(m_pc); f.taken = p.taken;
      f.tgt = {p.tgt[31:2], 2'b00}; f.st = p.st; f.known = 1'b1; f.pcf = '0;
      inflight.push_back(f);
      m_pc = p.taken ? {p.tgt[31:2], 2'b00} : m_pc + 32'd4;
    end
    cur.pcf = m_pc;
    exp_q.push_back(cur);
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    @(negedge clk);
    drive(s, r, rpc);
  endtask

  // Monitor: compare DUT outputs against the scoreboard after every edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_fetch", pc_fetch, e.pcf);
        chk("ifid_valid", ifid_valid, e.valid);
        chk("ifid_instr", ifid_instr, e.instr);
        if (e.known) begin
          chk("ifid_pc", ifid_pc, e.pc);
          chk("ifid_pred_taken", ifid_pred_taken, e.taken);
          chk("ifid_pred_target", ifid_pred_target, e.tgt);
          chk("ifid_bp_state", ifid_bp_state, e.st);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    d_en = 1'b1; d_pc = 32'h108; d_tgt = 32'h200; d_st = 2'b11; rnd_pred = 1'b0;
    model_reset();
    #12;
    check_reset();

    // Release, sequential fetch then a predicted-taken branch at 0x108
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0);
    repeat (9) step(0, 0, 0);

    // One-cycle redirect to an unaligned address
    step(0, 1, 32'h333);
    repeat (5) step(0, 0, 0);

    // Three-cycle stall mid-stream
    repeat (3) step(1, 0, 0);
    repeat (4) step(0, 0, 0);

    // Stall and redirect together
    step(1, 1, 32'h40);
    repeat (4) step(0, 0, 0);

    // PC wrap-around
    step(0, 1, 32'hFFFF_FFFC);
    repeat (4) step(0, 0, 0);

    // Randomized stalls, redirects and predictions
    d_en = 1'b0;
    rnd_pred = 1'b1;
    repeat (400) step(($urandom % 4) == 0, ($urandom % 10) == 0, $urandom);

    // Asynchronous reset mid-operation
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0);
    repeat (6) step(0, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage RISC-V pipeline. It owns the PC register, drives `pc_fetch` into `branch_predictor` and the synchronous instruction memory, and selects the next PC from the prediction or from an ID-stage redirect. It presents the IF/ID pipeline register to decode. The predictor's FSM state travels with each instruction so that ID can return it as `resolved_state`.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: instruction inserted on bubbles (`addi x0,x0,0`).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `stall` in 1: hazard unit hold request for IF and IF/ID.
- `redirect_en` in 1: ID resolved a misprediction; redirect fetch.
- `redirect_pc` in 32: correct next PC; bits [1:0] are ignored and forced to 0.
- `pc_fetch` out 32: current fetch PC, sent to the predictor.
- `bp_prediction_taken` in 1: predictor output for `pc_fetch`.
- `bp_predicted_target` in 32: predictor output for `pc_fetch`.
- `bp_state` in 2: predictor FSM state for `pc_fetch`.
- `imem_en` out 1: memory read enable.
- `imem_addr` out 32: memory address, always equal to `pc_fetch`.
- `imem_rdata` in 32: memory data. The contract is 1-cycle latency: the data for the address sampled at edge N is valid after edge N. `imem_rdata` holds its value on edges where `imem_en`=0.
- `ifid_valid` out 1: IF/ID holds a real instruction.
- `ifid_pc` out 32: IF/ID instruction PC.
- `ifid_instr` out 32: IF/ID instruction word.
- `ifid_pred_taken` out 1: prediction taken flag for the IF/ID instruction.
- `ifid_pred_target` out 32: predicted target for the IF/ID instruction.
- `ifid_bp_state` out 2: predictor FSM state for the IF/ID instruction.

## Operation
- Three register groups:
  - `pc_q`, the F1 issue stage.
  - F2 tag: `f2_valid`, `f2_pc`, `f2_pred_taken`, `f2_pred_target`, `f2_state`. It describes the request whose data is on `imem_rdata`.
  - IF/ID register.
- `pc_fetch = imem_addr = pc_q`.
- `imem_en = ~rst & (~stall | redirect_en)`.
- Next-PC priority, highest first:
  1. `redirect_en` → `{redirect_pc[31:2],2'b00}`.
  2. `stall` → `pc_q`.
  3. `bp_prediction_taken` → `{bp_predicted_target[31:2],2'b00}`.
  4. Otherwise → `pc_q+4`, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- F2 update:
  - `redirect_en` → `f2_valid`<=0.
  - Else if `stall` → hold.
  - Else → `f2_valid`<=1 and capture {`pc_q`, `bp_prediction_taken`, target, `bp_state`}. The captured prediction is the one used for next-PC.
- IF/ID update:
  - `redirect_en` → `ifid_valid`<=0, `ifid_instr`<=`NOP_INSTR`, other fields <=0.
  - Else if `stall` → hold all fields.
  - Else → `ifid_valid`<=`f2_valid`, `ifid_instr`<=(`f2_valid` ? `imem_rdata` : `NOP_INSTR`), remaining fields <= F2 tag.
- Redirect beats stall whenever both are asserted in the same cycle.
- The block has no tag check on predictions. `bp_prediction_taken` is used exactly as given.

## Timing
- Reset, asynchronous, applied immediately:
  - `pc_q`=`RESET_PC`.
  - `f2_valid`=0, F2 fields 0.
  - `ifid_valid`=0, `ifid_instr`=`NOP_INSTR`, other `ifid_*`=0.
  - `imem_en`=0 while `rst` is high.
- Reset released before edge E0: `RESET_PC` is issued at E0, F2 becomes valid after E0, and IF/ID is valid with the `RESET_PC` instruction after E1. Steady state is one instruction per cycle.
- Prediction is zero-bubble: the predicted target is issued in the cycle right after the branch is issued.
- Redirect asserted in cycle N:
  - After edge N: `pc_q`=`redirect_pc`, F2 invalid, IF/ID invalid.
  - Target instruction is valid in IF/ID after edge N+2.
  - Two bubbles reach ID.
- Stall held for K cycles: `pc_q`, F2, IF/ID and `imem_rdata` are frozen. Fetch resumes with no lost or duplicated instruction.
- Reset asserted mid-operation: all state returns to reset values at once. No in-flight instruction survives.

## Test plan
- Reset with `RESET_PC`=0x100, no prediction: IF/ID shows pc 0x100, 0x104, 0x108 with the matching memory words, `ifid_valid`=1 from the second edge after release.
- Predictor returns taken, target 0x200, `bp_state`=2'b11 at pc 0x108: next issued pc is 0x200. IF/ID for 0x108 carries `pred_taken`=1, `pred_target`=0x200, `bp_state`=3. IF/ID for 0x200 follows the cycle after, with no bubble.
- `redirect_en` with `redirect_pc`=0x333 for one cycle: two `ifid_valid`=0 cycles carrying `NOP_INSTR`, then pc 0x330 valid.
- `stall` for 3 cycles mid-stream: IF/ID holds the same pc/instr for 3 cycles, then continues with pc+4. No instruction is skipped or repeated.
- `stall` and `redirect_en` asserted together (`redirect_pc`=0x40): redirect wins. Bubbles appear, then 0x40.
- `pc_q`=0xFFFF_FFFC, not taken: next pc is 0x0000_0000.
